// File: rtl/cronometro_bcd_pkg.sv
// ----------------------------------------------------------------------------
// cronometro_bcd_pkg
// Shared definitions for the BCD stopwatch: FSM state enumeration, BCD digit
// geometry, display blink half-period and the BCD counting helpers.
// ----------------------------------------------------------------------------
package cronometro_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } estado_t;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   // Display blink half-period in STOP, in ticks (5 x 0.1 s = 0.5 s).
   localparam int BLINK_TICKS = 5;

   // Index 0 = tenths, 1 = units, 2 = tens, 3 = hundreds.
   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] contagem_t;

   // Ripple-carry BCD increment; a digit at (or, defensively, above) 9
   // wraps to 0 and passes the carry on.
   function automatic contagem_t bcd_incrementa(input contagem_t c);
      contagem_t r;
      logic      carry;
      r     = c;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (c[i] >= DIGIT_MAX) begin
               r[i]  = '0;
               carry = 1'b1;
            end else begin
               r[i]  = c[i] + 1'b1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // True when every digit is 9 (999.9).
   function automatic logic bcd_no_maximo(input contagem_t c);
      logic m;
      m = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c[i] != DIGIT_MAX) m = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/cronometro_bcd_sincroniza_botao.sv
// ----------------------------------------------------------------------------
// sincroniza_botao
// Two-flop synchronizer for an asynchronous level button, followed by a
// previous-value flop for rising-edge detection.
//
// Ports
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   botao  in  1  raw asynchronous button level
//   pulso  out 1  one-cycle request pulse (sync AND NOT previous)
//
// The pulse is built from flops only, so the consumer can register its
// effect on the next edge: input sampled high at edge 1, action visible at
// edge 3.
// ----------------------------------------------------------------------------
module sincroniza_botao (
   input  logic clk,
   input  logic rst_n,
   input  logic botao,
   output logic pulso
);

   logic       meta;
   logic       sinc;
   logic       anterior;
   // Shift register of ones filled after reset release: bit 2 says that
   // "anterior" now holds a real sample rather than the reset value, so a
   // button held high across reset release never produces a pulse; it must
   // be seen low first.
   logic [2:0] valido;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= 1'b0;
         sinc     <= 1'b0;
         anterior <= 1'b0;
         valido   <= '0;
      end else begin
         meta     <= botao;
         sinc     <= meta;
         anterior <= sinc;
         valido   <= {valido[1:0], 1'b1};
      end
   end

   assign pulso = sinc & ~anterior & valido[2];

endmodule

// File: rtl/cronometro_bcd.sv
// ----------------------------------------------------------------------------
// cronometro_bcd
// Stopwatch counting tenths of a second up to 999.9 in BCD, with start/stop,
// clear and lap-hold buttons and a blinking display enable while stopped.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count rate in Hz (10 = one count per tenth of a second)
//
// Ports
//   clk           in  1  clock, rising edge
//   rst_n         in  1  asynchronous active-low reset
//   btn_start     in  1  start/stop toggle request (async level)
//   btn_zero      in  1  clear request (async level)
//   btn_parcial   in  1  lap-hold toggle request (async level)
//   centena       out 4  BCD hundreds of seconds
//   dezena        out 4  BCD tens of seconds
//   unidade       out 4  BCD units of seconds
//   decimo        out 4  BCD tenths of seconds
//   displayativo  out 1  display enable for the 7-segment decoder
//   rodando       out 1  high while running
// ----------------------------------------------------------------------------
module cronometro_bcd
   import cronometro_bcd_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_zero,
   input  logic       btn_parcial,
   output logic [3:0] centena,
   output logic [3:0] dezena,
   output logic [3:0] unidade,
   output logic [3:0] decimo,
   output logic       displayativo,
   output logic       rodando
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam int BW  = $clog2(BLINK_TICKS);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

   logic p_start;
   logic p_zero;
   logic p_parcial;

   sincroniza_botao u_sinc_start (
      .clk   (clk),
      .rst_n (rst_n),
      .botao (btn_start),
      .pulso (p_start)
   );

   sincroniza_botao u_sinc_zero (
      .clk   (clk),
      .rst_n (rst_n),
      .botao (btn_zero),
      .pulso (p_zero)
   );

   sincroniza_botao u_sinc_parcial (
      .clk   (clk),
      .rst_n (rst_n),
      .botao (btn_parcial),
      .pulso (p_parcial)
   );

   estado_t       estado,     estado_nxt;
   logic [PW-1:0] presc,      presc_nxt;
   contagem_t     contagem,   contagem_nxt;
   contagem_t     exibido,    exibido_nxt;
   logic          hold,       hold_nxt;
   logic          disp_q,     disp_nxt;
   logic [BW-1:0] blink_cnt,  blink_nxt;
   logic          rodando_q;
   logic          tick;
   logic          entra_stop;

   assign tick = (presc == PRESC_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= IDLE;
      end else begin
         estado <= estado_nxt;
      end
   end

   always_comb begin
      estado_nxt   = estado;
      contagem_nxt = contagem;
      hold_nxt     = hold;
      disp_nxt     = disp_q;
      blink_nxt    = blink_cnt;
      entra_stop   = 1'b0;
      // Prescaler free-runs; only entry into RUN reloads it.
      presc_nxt    = tick ? '0 : presc + 1'b1;

      if (p_zero) begin
         // Clear outranks every other request and the tick.
         estado_nxt   = IDLE;
         contagem_nxt = '0;
         hold_nxt     = 1'b0;
         disp_nxt     = 1'b1;
         blink_nxt    = '0;
      end else begin
         case (estado)
            IDLE: begin
               disp_nxt = 1'b1;
               if (p_start) begin
                  estado_nxt = RUN;
                  presc_nxt  = '0;
               end
            end
            RUN: begin
               disp_nxt = 1'b1;
               if (p_parcial) hold_nxt = ~hold;
               if (tick) begin
                  // At 999.9 the count saturates and the watch stops itself.
                  if (bcd_no_maximo(contagem)) entra_stop = 1'b1;
                  else                         contagem_nxt = bcd_incrementa(contagem);
               end
               if (p_start) entra_stop = 1'b1;
               if (entra_stop) begin
                  estado_nxt = STOP;
                  hold_nxt   = 1'b0;
                  disp_nxt   = 1'b1;
                  blink_nxt  = '0;
               end
            end
            STOP: begin
               if (p_start) begin
                  estado_nxt = RUN;
                  presc_nxt  = '0;
                  disp_nxt   = 1'b1;
               end else if (tick) begin
                  if (blink_cnt == BLINK_MAX) begin
                     blink_nxt = '0;
                     disp_nxt  = ~disp_q;
                  end else begin
                     blink_nxt = blink_cnt + 1'b1;
                  end
               end
            end
            default: begin
               estado_nxt = IDLE;
            end
         endcase
      end

      // Frozen lap value simply keeps the previously shown digits.
      exibido_nxt = hold_nxt ? exibido : contagem_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         contagem  <= '0;
         exibido   <= '0;
         hold      <= 1'b0;
         disp_q    <= 1'b1;
         blink_cnt <= '0;
         rodando_q <= 1'b0;
      end else begin
         presc     <= presc_nxt;
         contagem  <= contagem_nxt;
         exibido   <= exibido_nxt;
         hold      <= hold_nxt;
         disp_q    <= disp_nxt;
         blink_cnt <= blink_nxt;
         rodando_q <= (estado_nxt == RUN);
      end
   end

   assign centena      = exibido[3];
   assign dezena       = exibido[2];
   assign unidade      = exibido[1];
   assign decimo       = exibido[0];
   assign displayativo = disp_q;
   assign rodando      = rodando_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
// ----------------------------------------------------------------------------
// tb_cronometro_bcd
// Bench for cronometro_bcd at CLK_HZ=100, TICK_HZ=10 (10 cycles per tick).
// A behavioural stopwatch model (integer tenths, plain state flags) is
// compared with the outputs on every falling edge; directed scenarios add
// hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_cronometro_bcd;

   localparam int CLK_HZ  = 100;
   localparam int TICK_HZ = 10;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_zero = 1'b0;
   logic       btn_parcial = 1'b0;
   logic [3:0] centena, dezena, unidade, decimo;
   logic       displayativo, rodando;

   always #5 clk = ~clk;

   cronometro_bcd #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_start    (btn_start),
      .btn_zero     (btn_zero),
      .btn_parcial  (btn_parcial),
      .centena      (centena),
      .dezena       (dezena),
      .unidade      (unidade),
      .decimo       (decimo),
      .displayativo (displayativo),
      .rodando      (rodando)
   );

   int total = 0;
   int bad   = 0;
   int nfail_print = 0;

   task automatic check(input string nome, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         if (nfail_print < 40) begin
            nfail_print++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
         end
      end
   endtask

   // ---------------- behavioural model ----------------
   int  m_state, m_count, m_frozen, m_presc, m_stop_ticks, m_edges, m_before;
   bit  m_hold, m_disp, m_tick, m_to_stop;
   bit  hs[3][3];   // per button (0 zero, 1 start, 2 parcial): samples k-1, k-2, k-3
   bit  mcur[3];
   bit  mp[3];
   bit  pre_req = 1'b0;
   int  pre_tenths = 0;
   logic [15:0] preload_v = '0;

   task automatic model_reset();
      m_state = M_IDLE; m_count = 0; m_frozen = 0; m_presc = 0;
      m_stop_ticks = 0; m_edges = 0; m_hold = 0; m_disp = 1;
      for (int b = 0; b < 3; b++)
         for (int j = 0; j < 3; j++) hs[b][j] = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         mcur[0] = btn_zero; mcur[1] = btn_start; mcur[2] = btn_parcial;
         m_edges++;
         // A request fires when a button was seen low and then high, two
         // edges after that high sample.
         for (int b = 0; b < 3; b++) begin
            mp[b] = (m_edges >= 4) && hs[b][1] && !hs[b][2];
            hs[b][2] = hs[b][1];
            hs[b][1] = hs[b][0];
            hs[b][0] = mcur[b];
         end
         if (pre_req) begin
            m_count = pre_tenths;
            pre_req = 1'b0;
         end
         m_tick   = (m_presc == DIV - 1);
         m_presc  = m_tick ? 0 : m_presc + 1;
         m_before = m_hold ? m_frozen : m_count;
         if (mp[0]) begin
            m_state = M_IDLE; m_count = 0; m_hold = 0; m_disp = 1;
         end else if (m_state == M_IDLE) begin
            if (mp[1]) begin m_state = M_RUN; m_presc = 0; end
         end else if (m_state == M_RUN) begin
            m_to_stop = mp[1];
            if (m_tick) begin
               if (m_count == 9999) m_to_stop = 1;
               else                 m_count = m_count + 1;
            end
            if (m_to_stop) begin
               m_state = M_STOP; m_hold = 0; m_disp = 1; m_stop_ticks = 0;
            end else if (mp[2]) begin
               if (!m_hold) m_frozen = m_before;
               m_hold = !m_hold;
            end
         end else begin
            if (mp[1]) begin
               m_state = M_RUN; m_presc = 0;
            end else if (m_tick) begin
               m_stop_ticks++;
               if (m_stop_ticks % 5 == 0) m_disp = !m_disp;
            end
         end
      end
   end

   always @(negedge clk) begin
      int sh;
      sh = m_hold ? m_frozen : m_count;
      check("mod_centena", int'(centena), (sh / 1000) % 10);
      check("mod_dezena",  int'(dezena),  (sh / 100) % 10);
      check("mod_unidade", int'(unidade), (sh / 10) % 10);
      check("mod_decimo",  int'(decimo),  sh % 10);
      check("mod_rodando", int'(rodando), (m_state == M_RUN) ? 1 : 0);
      check("mod_display", int'(displayativo), (m_state == M_STOP) ? int'(m_disp) : 1);
   end

   // ---------------- directed stimulus ----------------
   task automatic ciclos(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Low for two cycles, high for three; returns on the falling edge right
   // after the edge where the action becomes visible.
   task automatic aperta(input int qual);
      ciclos(2);
      case (qual)
         0: btn_zero = 1'b1;
         1: btn_start = 1'b1;
         default: btn_parcial = 1'b1;
      endcase
      ciclos(3);
      btn_zero = 1'b0; btn_start = 1'b0; btn_parcial = 1'b0;
   endtask

   task automatic preload(input logic [15:0] v, input int t);
      @(negedge clk);
      preload_v  = v;
      pre_tenths = t;
      pre_req    = 1'b1;
      force dut.contagem = preload_v;
      @(negedge clk);
      release dut.contagem;
   endtask

   task automatic digits(input string nome, input int c, input int d, input int u, input int t);
      check({nome, "_centena"}, int'(centena), c);
      check({nome, "_dezena"},  int'(dezena),  d);
      check({nome, "_unidade"}, int'(unidade), u);
      check({nome, "_decimo"},  int'(decimo),  t);
   endtask

   initial begin
      int v;
      // Reset state
      ciclos(3);
      digits("rst", 0, 0, 0, 0);
      check("rst_rodando", int'(rodando), 0);
      check("rst_display", int'(displayativo), 1);
      rst_n = 1'b1;
      ciclos(6);

      // Start latency and first counts
      btn_start = 1'b1;
      ciclos(1); check("start_edge1_rodando", int'(rodando), 0);
      ciclos(1); check("start_edge2_rodando", int'(rodando), 0);
      ciclos(1); check("start_edge3_rodando", int'(rodando), 1);
      btn_start = 1'b0;
      ciclos(9);  check("entry9_decimo", int'(decimo), 0);
      ciclos(1);  check("entry10_decimo", int'(decimo), 1);
      ciclos(90); check("entry100_unidade", int'(unidade), 1);
      check("entry100_decimo", int'(decimo), 0);

      // Carry chains
      ciclos(890); digits("c009_9", 0, 0, 9, 9);
      ciclos(10);  digits("c010_0", 0, 1, 0, 0);
      aperta(1);   check("stop1_rodando", int'(rodando), 0);
      preload(16'h0999, 999);
      digits("pre099_9", 0, 9, 9, 9);
      aperta(1);   check("run2_rodando", int'(rodando), 1);
      ciclos(9);   digits("c099_9", 0, 9, 9, 9);
      ciclos(1);   digits("c100_0", 1, 0, 0, 0);

      // Saturation at 999.9 and blink
      aperta(1);
      preload(16'h9998, 9998);
      aperta(1);
      ciclos(10);  digits("c999_9", 9, 9, 9, 9);
      check("c999_9_rodando", int'(rodando), 1);
      ciclos(10);  digits("sat", 9, 9, 9, 9);
      check("sat_rodando", int'(rodando), 0);
      check("sat_display", int'(displayativo), 1);
      ciclos(49);  check("blink49", int'(displayativo), 1);
      ciclos(1);   check("blink50", int'(displayativo), 0);
      ciclos(49);  check("blink99", int'(displayativo), 0);
      ciclos(1);   check("blink100", int'(displayativo), 1);
      ciclos(50);  check("blink150", int'(displayativo), 0);
      digits("sat_end", 9, 9, 9, 9);

      // Lap hold
      aperta(0);   digits("zero1", 0, 0, 0, 0);
      aperta(1);
      aperta(1);
      preload(16'h0123, 123);
      aperta(1);
      btn_parcial = 1'b1; ciclos(1); btn_parcial = 1'b0;
      ciclos(2);    digits("hold3", 0, 1, 2, 3);
      ciclos(197);  digits("hold200", 0, 1, 2, 3);
      ciclos(1800); digits("hold2000", 0, 1, 2, 3);
      check("hold2000_rodando", int'(rodando), 1);
      btn_parcial = 1'b1; ciclos(1); btn_parcial = 1'b0;
      ciclos(2);
      v = int'(centena) * 1000 + int'(dezena) * 100 + int'(unidade) * 10 + int'(decimo);
      check("unhold_live_near_323", (v >= 322 && v <= 324) ? 1 : 0, 1);

      // Simultaneous zero and start while running
      ciclos(5);
      btn_zero = 1'b1; btn_start = 1'b1;
      ciclos(3);
      digits("zs", 0, 0, 0, 0);
      check("zs_rodando", int'(rodando), 0);
      check("zs_display", int'(displayativo), 1);
      btn_zero = 1'b0; btn_start = 1'b0;
      ciclos(10);
      check("zs_later_rodando", int'(rodando), 0);
      check("zs_later_decimo", int'(decimo), 0);

      // Asynchronous reset mid-run with start held across release
      aperta(1);
      aperta(1);
      preload(16'h0456, 456);
      aperta(1);
      ciclos(5);   digits("r045_6", 0, 4, 5, 6);
      btn_start = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      digits("async_rst", 0, 0, 0, 0);
      check("async_rst_rodando", int'(rodando), 0);
      check("async_rst_display", int'(displayativo), 1);
      ciclos(2);
      rst_n = 1'b1;
      ciclos(20);
      check("held_start_rodando", int'(rodando), 0);
      check("held_start_decimo", int'(decimo), 0);
      btn_start = 1'b0;
      ciclos(3);
      aperta(1);
      check("restart_rodando", int'(rodando), 1);
      ciclos(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
